// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame geometry, common command bytes
// and small helpers for parity, frame assembly and counter sizing.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    REQ      = 3'd2,
    SHIFT    = 3'd3,
    ACK      = 3'd4,
    WAIT_BUS = 3'd5
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 10;
  localparam int PS2_ACK_EDGE   = 11;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Transmit order is bit 0 first: D0..D7, parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] make_frame(input logic [7:0] d);
    return {1'b1, odd_parity(d), d};
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus registered falling-edge detector for one PS/2 line.
// The fall pulse appears 3 clk cycles after the pin edge; lines idle high.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = line_in;
    sync_d = meta_q;
    prev_d = sync_q;
    fall_d = prev_q & ~sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
    end
  end

  assign line_sync = sync_q;
  assign fall      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked-out frame, ack check.
// Define PS2_TX_TIMEOUT_EN to add the device-clock watchdog (TIMEOUT_CYC cycles between falls).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 3000,
  parameter int REQ_CYC     = 16,
  parameter int TIMEOUT_CYC = 400000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err
);

  localparam int CW = cnt_w((INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC);
  localparam int BW = $clog2(PS2_ACK_EDGE + 1);
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] REQ_LAST   = CW'(REQ_CYC - 1);
  localparam logic [BW-1:0] FRAME_LAST = BW'(PS2_FRAME_BITS - 1);

  ps2_state_e                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d, cnt_inc_s;
  logic [BW-1:0]             bit_q, bit_d, bit_inc_s;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic                      clk_oe_q, clk_oe_d;
  logic                      data_oe_q, data_oe_d;
  logic                      tx_ready_q, tx_ready_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      ack_q, ack_d;

  logic clk_sync_s, clk_fall_s;
  logic data_sync_s, data_fall_unused;
  logic tout_hit_s;

  ps2_line_sync u_clk_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync_s),
    .fall      (clk_fall_s)
  );

  ps2_line_sync u_data_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_in   (ps2_data_in),
    .line_sync (data_sync_s),
    .fall      (data_fall_unused)
  );

  assign cnt_inc_s = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign bit_inc_s = (&bit_q) ? bit_q : bit_q + BW'(1);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT_CYC);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tout_q, tout_d;
  logic          tout_run_s;

  // Watchdog restarts on every device clock fall and idles at zero outside the clocked phase.
  always_comb begin
    tout_run_s = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_BUS);
    if (!tout_run_s || clk_fall_s) begin
      tout_d = {TW{1'b0}};
    end else if (&tout_q) begin
      tout_d = tout_q;
    end else begin
      tout_d = tout_q + TW'(1);
    end
  end

  assign tout_hit_s = tout_run_s && !clk_fall_s && (tout_q == TOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tout_q <= {TW{1'b0}};
    end else begin
      tout_q <= tout_d;
    end
  end
`else
  // Without the watchdog a silent device simply stalls the transfer until reset.
  assign tout_hit_s = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    tx_ready_d = tx_ready_q;
    ack_d      = ack_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        tx_ready_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          frame_d    = make_frame(tx_data);
          clk_oe_d   = 1'b1;
          tx_ready_d = 1'b0;
          cnt_d      = {CW{1'b0}};
          state_d    = INHIBIT;
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = {CW{1'b0}};
          data_oe_d = 1'b1;
          state_d   = REQ;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      REQ: begin
        if (cnt_q == REQ_LAST) begin
          clk_oe_d = 1'b0;
          bit_d    = {BW{1'b0}};
          state_d  = SHIFT;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      SHIFT: begin
        // Data changes while the device holds its clock low; stop bit releases the line.
        if (clk_fall_s) begin
          data_oe_d = ~frame_q[bit_q];
          bit_d     = bit_inc_s;
          if (bit_q == FRAME_LAST) begin
            state_d = ACK;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      ACK: begin
        if (clk_fall_s) begin
          ack_d   = ~data_sync_s;
          bit_d   = bit_inc_s;
          state_d = WAIT_BUS;
        end else begin
          state_d = ACK;
        end
      end
      WAIT_BUS: begin
        if (clk_sync_s && data_sync_s) begin
          done_d     = ack_q;
          err_d      = ~ack_q;
          tx_ready_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = WAIT_BUS;
        end
      end
      default: begin
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        tx_ready_d = 1'b1;
        state_d    = IDLE;
      end
    endcase

    if (tout_hit_s) begin
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b1;
      tx_ready_d = 1'b1;
      state_d    = IDLE;
    end else begin
      ack_d = ack_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      bit_q      <= {BW{1'b0}};
      frame_q    <= {PS2_FRAME_BITS{1'b1}};
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
// Timing parameters are scaled down so every scenario fits in a short run.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 60;
  localparam int REQ  = 16;
  localparam int HALF = 20;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TOUT = 1000;
`else
  localparam int TOUT = 400000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, clk_oe, data_oe, done, err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = dev_clk & ~clk_oe;
  assign ps2_data_in = dev_data & ~data_oe;

  int errors = 0;
  int checks = 0;
  int exp_q[$];  // 1 = done expected, 2 = err expected

  ps2_host_tx #(
    .INHIBIT_CYC (INH),
    .REQ_CYC     (REQ),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Line sequence the device should see: start, D0..D7, odd parity, stop.
  function automatic logic [10:0] model_bits(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_ready) check("idle_lines_released", {30'd0, clk_oe, data_oe}, 32'd0);
      if (done || err) begin
        check("done_err_exclusive", {31'd0, done & err}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, done, err}, 32'd0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("pulse_kind", {30'd0, done, err}, (e == 1) ? 32'd2 : 32'd1);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [7:0] d, input bit hold, input logic [7:0] hd);
    @(negedge clk);
    check("ready_before_accept", {31'd0, tx_ready}, 32'd1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1;
    if (hold) tx_data = hd;
    else tx_valid = 1'b0;
  endtask

  task automatic preamble();
    int n;
    @(negedge clk);
    check("ready_low_after_accept", {31'd0, tx_ready}, 32'd0);
    check("clk_oe_after_accept", {31'd0, clk_oe}, 32'd1);
    n = 0;
    while (clk_oe && !data_oe && n < INH + 50) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_cycles", n, INH);
    n = 0;
    while (clk_oe && data_oe && n < REQ + 50) begin
      n++;
      @(negedge clk);
    end
    check("request_cycles", n, REQ);
    check("start_bit_held", {30'd0, clk_oe, data_oe}, 32'd1);
  endtask

  task automatic device(input logic [7:0] d, input bit ack, input int abort_k);
    logic [10:0] got, exp;
    exp = model_bits(d);
    got = 11'd0;
    got[0] = ps2_data_in;
    for (int k = 1; k <= 11; k++) begin
      wait_cycles(HALF);
      dev_clk = 1'b0;
      if (k == 1) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("data_oe_3_cycles_after_fall", {31'd0, data_oe}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("data_oe_4_cycles_after_fall", {31'd0, data_oe}, {31'd0, ~exp[1]});
        wait_cycles(HALF - 4);
      end else if (k == abort_k) begin
        wait_cycles(6);
        check("data_oe_before_reset", {31'd0, data_oe}, {31'd0, ~exp[k]});
        rst_n = 1'b0;
        #1;
        check("clk_oe_async_reset", {31'd0, clk_oe}, 32'd0);
        check("data_oe_async_reset", {31'd0, data_oe}, 32'd0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        return;
      end else begin
        wait_cycles(HALF);
      end
      if (k <= 10) got[k] = ps2_data_in;
      dev_clk = 1'b1;
      if (k == 10 && ack) begin
        wait_cycles(5);
        dev_data = 1'b0;
      end
    end
    wait_cycles(5);
    dev_data = 1'b1;
    check("frame_bits", {21'd0, got}, {21'd0, exp});
  endtask

  task automatic finish_tx();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready && n < 500);
    check("ready_returns", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    check("outcome_pulses_seen", exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    check("model_0xED", {21'd0, model_bits(PS2_CMD_SET_LED)}, 32'h7DA);
    check("model_0x01", {21'd0, model_bits(8'h01)}, 32'h402);
    check("model_0xFF", {21'd0, model_bits(PS2_CMD_RESET)}, 32'h7FE);

    repeat (3) @(negedge clk);
    check("reset_state", {27'd0, tx_ready, clk_oe, data_oe, done, err}, 32'h10);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED acknowledged
    exp_q.push_back(1);
    start_tx(PS2_CMD_SET_LED, 1'b0, 8'h00);
    preamble();
    device(PS2_CMD_SET_LED, 1'b1, 0);
    finish_tx();

    // 0x01: parity bit 0
    exp_q.push_back(1);
    start_tx(8'h01, 1'b0, 8'h00);
    preamble();
    device(8'h01, 1'b1, 0);
    finish_tx();

    // 0xFF not acknowledged
    exp_q.push_back(2);
    start_tx(PS2_CMD_RESET, 1'b0, 8'h00);
    preamble();
    device(PS2_CMD_RESET, 1'b0, 0);
    finish_tx();

    // Reset after the 4th device clock fall aborts silently
    start_tx(8'h01, 1'b0, 8'h00);
    preamble();
    device(8'h01, 1'b1, 4);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", {29'd0, tx_ready, clk_oe, data_oe}, 32'h4);
    repeat (100) @(negedge clk);
    check("no_pulse_after_abort", exp_q.size(), 32'd0);

`ifdef PS2_TX_TIMEOUT_EN
    // Silent device: watchdog fires TOUT cycles after entering SHIFT
    exp_q.push_back(2);
    start_tx(8'h01, 1'b0, 8'h00);
    preamble();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 2 * TOUT);
    check("timeout_cycles", n, TOUT);
    check("timeout_lines_released", {30'd0, clk_oe, data_oe}, 32'd0);
    finish_tx();
`else
    // Silent device: transfer stalls in SHIFT with the start bit still driven
    start_tx(8'h01, 1'b0, 8'h00);
    preamble();
    repeat (1500) @(negedge clk);
    check("stall_in_shift", {29'd0, tx_ready, clk_oe, data_oe}, 32'h1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
`endif

    // tx_valid held high with a new byte during a transfer
    exp_q.push_back(1);
    exp_q.push_back(1);
    start_tx(PS2_CMD_SET_LED, 1'b1, 8'h55);
    preamble();
    device(PS2_CMD_SET_LED, 1'b1, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 500);
    check("done_seen_while_held", {31'd0, done}, 32'd1);
    check("ready_with_done", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    preamble();
    device(8'h55, 1'b1, 0);
    finish_tx();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
